fifo_prog: RTL
==============

Name: fifo_prog

Overview:
Parametrised synchronous FIFO that generalises the current UART FIFO. It adds:
- any depth ≥2, including non-power-of-2;
- a selectable read mode: registered or first-word-fall-through (FWFT);
- runtime-programmable almost-full and almost-empty thresholds;
- an occupancy count;
- sticky overflow and underflow error flags;
- a synchronous flush.

It sits between the UART RX/TX datapaths and the bus-side register interface.

Parameters:
WIDTH, 8, data word width in bits (≥1)
DEPTH, 16, number of entries (≥2; need not be a power of 2)
FWFT, 0, 0 = registered read (data one cycle after pop); 1 = show-ahead (head word visible while not empty)
AW, $clog2(DEPTH), pointer width (derived; not to be overridden)
CW, $clog2(DEPTH+1), count width (derived; not to be overridden)

Ports:
clk_i  in  1  clock; all logic is on the rising edge
rst_i  in  1  reset; asynchronous, active-high
flush_i  in  1  synchronous clear of contents
push_i  in  1  write request
pop_i  in  1  read request
data_i  in  WIDTH  write data
data_o  out  WIDTH  read data
af_thresh_i  in  CW  almost-full threshold
ae_thresh_i  in  CW  almost-empty threshold
clr_err_i  in  1  clears the sticky error flags
count_o  out  CW  current occupancy, 0..DEPTH
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
almost_full_o  out  1  count >= af_thresh_i
almost_empty_o  out  1  count <= ae_thresh_i
overflow_o  out  1  sticky; a push was dropped
underflow_o  out  1  sticky; a pop was dropped

Behaviour:
Reset (rst_i high, asynchronous):
- wr_ptr, rd_ptr and count go to 0.
- data_o = 0 when FWFT=0.
- overflow_o = 0, underflow_o = 0.
- Resulting outputs: empty_o=1, full_o=0, almost_empty_o=1 (because count 0 <= any threshold), almost_full_o = (af_thresh_i==0).
- Storage array is not reset.
- Reset mid-operation discards all contents immediately.

Accept rules, evaluated per cycle:
- push_acc = push_i & (!full_o | pop_acc).
- pop_acc = pop_i & !empty_o.
- Push and pop while full: both accepted, count unchanged, no overflow.
- Push and pop while empty: push accepted, pop dropped, underflow set.

Pointer and count update:
- Accepted push writes mem[wr_ptr] = data_i and advances wr_ptr.
- Accepted pop advances rd_ptr.
- Pointers wrap from DEPTH-1 to 0 (explicit compare, no power-of-2 masking).
- count += push_acc − pop_acc.

Error flags:
- Dropped push (push_i & !push_acc) sets overflow_o on the next edge.
- Dropped pop (pop_i & !pop_acc) sets underflow_o on the next edge.
- Both hold until clr_err_i.
- If clr_err_i and a new error occur in the same cycle, set wins.

Flush:
- flush_i has priority over push_i and pop_i in the same cycle.
- Next edge: pointers and count go to 0; data_o = 0 when FWFT=0.
- Error flags are unchanged. flush_i never raises an error.

Read path:
- FWFT=0: on pop_acc, data_o is loaded with mem[rd_ptr] at that edge, so data is valid in the cycle after the pop. data_o holds its value otherwise.
- FWFT=1: data_o = mem[rd_ptr] combinationally. It is valid whenever empty_o=0 and is undefined-but-stable when empty.
- Latency, write to read-visible:
  - FWFT=1: a word written at edge N is visible after edge N, and empty_o falls after edge N.
  - FWFT=0: the earliest pop is in cycle N+1, with data after edge N+1.

Flags:
- full_o, empty_o, almost_full_o and almost_empty_o are combinational from the count register and the threshold inputs.
- Threshold changes take effect in the same cycle.
- af_thresh_i > DEPTH means almost_full_o never asserts.

Test Plan:
1. WIDTH=8, DEPTH=4, FWFT=0, af=3, ae=1. Push 0x11,0x22,0x33,0x44 → count 1..4; almost_full_o after 3rd push; full_o after 4th. Pop ×4 → data_o 0x11,0x22,0x33,0x44, each one cycle after its pop; empty_o=1 at end.
2. Full FIFO (4 entries), push 0x55 → dropped; overflow_o=1; contents unchanged. Pulse clr_err_i → overflow_o=0.
3. Empty FIFO, pop_i=1 → underflow_o=1, count stays 0. In the same cycle as clr_err_i, repeat pop → underflow_o stays 1.
4. Full FIFO, push 0x66 together with pop → pop returns 0x11; count stays 4; no overflow. Draining yields 0x22,0x33,0x44,0x66.
5. DEPTH=5, FWFT=1. Run 12 push/pop cycles of an incrementing pattern so the pointers wrap past index 4 → data_o shows each head word while empty_o=0, in order, with no loss.
6. 3 entries and flush_i asserted together with push_i → next cycle count 0, empty_o=1, push ignored, error flags unchanged. Assert rst_i mid-burst → outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_prog.sv
// Synchronous FIFO with arbitrary depth, registered or show-ahead read port,
// runtime almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module fifo_prog #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int FWFT  = 0,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  input  logic [CW-1:0]    af_thresh_i,
  input  logic [CW-1:0]    ae_thresh_i,
  input  logic             clr_err_i,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push_acc, pop_acc, push_drop, pop_drop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  assign count_o        = count;
  assign full_o         = (count == CW'(DEPTH));
  assign empty_o        = (count == '0);
  assign almost_full_o  = (count >= af_thresh_i);
  assign almost_empty_o = (count <= ae_thresh_i);

  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  // Flush overrides both requests and must not be counted as a drop.
  assign pop_acc   = pop_i & ~empty_o & ~flush_i;
  assign push_acc  = push_i & (~full_o | pop_acc) & ~flush_i;
  assign push_drop = push_i & ~push_acc & ~flush_i;
  assign pop_drop  = pop_i & ~pop_acc & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_acc)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push_acc) - CW'(pop_acc);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) mem[wr_ptr] <= data_i;
  end

  // Set beats clear when both happen in one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push_drop)      overflow_o  <= 1'b1;
      else if (clr_err_i) overflow_o  <= 1'b0;
      if (pop_drop)       underflow_o <= 1'b1;
      else if (clr_err_i) underflow_o <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_o = mem[rd_ptr];
    end else begin : g_reg
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        data_o <= '0;
        else if (flush_i) data_o <= '0;
        else if (pop_acc) data_o <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule
